// File: rtl/cam_pkg.sv
// Shared definitions for the CAM search sequencer: default widths, host opcodes
// and the controller state encoding.
package cam_pkg;
  localparam int DEF_DATA_W = 14;
  localparam int DEF_ADDR_W = 12;

  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_SEARCH = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/cam_scan_cmp.sv
// One-deep read pipeline for the CAM scan: remembers which address (and entry
// validity) the RAM word now on dout belongs to, and compares it with the key.
module cam_scan_cmp #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_ent,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr
);
  logic              vld_p1;
  logic              ent_p1;
  logic [ADDR_W-1:0] addr_p1;

  // issue -> p1: aligned with the RAM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ent_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue_vld;
      ent_p1 <= issue_ent;
    end
    addr_p1 <= issue_addr;
  end

  assign hit      = vld_p1 && ent_p1 && (ram_dout == key);
  assign hit_addr = addr_p1;
endmodule

// File: rtl/cam_search_ctrl.sv
// Host-facing sequencer for the image-CAM base RAM: pass-through writes and
// lowest-address linear searches. Optional entry-valid bits: CAM_VALID_BITS_EN.
module cam_search_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic              ram_we,
  output logic              ram_match_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t            state;
  logic [ADDR_W-1:0] lim;
  logic [DATA_W-1:0] key;
  logic              hit;
  logic [ADDR_W-1:0] hit_addr;
  logic              issue_ent;

`ifdef CAM_VALID_BITS_EN
  logic [2**ADDR_W-1:0] entry_valid;

  // ram_addr holds the target address for the whole WRITE cycle
  always_ff @(posedge clk) begin
    if (rst) entry_valid <= '0;
    else if (state == ST_WRITE) entry_valid[ram_addr] <= 1'b1;
  end

  assign issue_ent = entry_valid[ram_addr];
`else
  assign issue_ent = 1'b1;
`endif

  cam_scan_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (ram_match_en),
    .issue_addr (ram_addr),
    .issue_ent  (issue_ent),
    .key        (key),
    .ram_dout   (ram_dout),
    .hit        (hit),
    .hit_addr   (hit_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_addr     <= '0;
      ram_we       <= 1'b0;
      ram_match_en <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            lim       <= cmd_addr;
            key       <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op == OP_WRITE) begin
              state    <= ST_WRITE;
              ram_we   <= 1'b1;
              ram_addr <= cmd_addr;
              ram_din  <= cmd_data;
            end else begin
              state        <= ST_SCAN;
              ram_match_en <= 1'b1;
              ram_addr     <= '0;
            end
          end
        end
        ST_WRITE: begin
          ram_we    <= 1'b0;
          ram_din   <= '0;
          ram_addr  <= '0;
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_addr  <= ram_addr;
          state     <= ST_RESP;
        end
        ST_SCAN: begin
          // A hit ends the scan at once; the address issued alongside it is dropped.
          if (hit) begin
            ram_match_en <= 1'b0;
            ram_addr     <= '0;
            rsp_valid    <= 1'b1;
            rsp_hit      <= 1'b1;
            rsp_addr     <= hit_addr;
            state        <= ST_RESP;
          end else if (ram_addr == lim) begin
            ram_match_en <= 1'b0;
            ram_addr     <= '0;
            state        <= ST_DRAIN;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit;
          rsp_addr  <= hit ? hit_addr : lim;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/cam_search_ctrl.md
Name: cam_search_ctrl

Overview:
Sequencer in front of the image-CAM base RAM.
- Accepts write and search commands from a host.
- Writes go straight through to the RAM.
- Searches scan RAM addresses 0..limit and compare each read word against a key.
- Returns the lowest matching address, or a miss.
- Sole owner of the RAM's we/match_en/addr/din pins.

Parameters:
DATA_W, 14, RAM word width / search key width
ADDR_W, 12, RAM address width; depth = 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  1  0 = write, 1 = search
cmd_addr  in  ADDR_W  write: target address; search: inclusive upper scan limit
cmd_data  in  DATA_W  write: data; search: key
rsp_valid  out  1  one-cycle response pulse
rsp_hit  out  1  search found a match (always 0 for writes)
rsp_addr  out  ADDR_W  write: address written; search hit: lowest match address; search miss: limit
busy  out  1  high in any state other than IDLE
ram_we  out  1  to RAM we
ram_match_en  out  1  to RAM match_en (read enable)
ram_addr  out  ADDR_W  to RAM addr
ram_din  out  DATA_W  to RAM din
ram_dout  in  DATA_W  from RAM dout; valid one clk after ram_addr is presented with ram_match_en=1

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_hit=0, rsp_addr=0, ram_we=0, ram_match_en=0, ram_addr=0, ram_din=0.
- States: IDLE, WRITE, SCAN, DRAIN, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op/addr/data (key, limit).
  - Go to WRITE if op=0, SCAN if op=1.
- WRITE (1 cycle):
  - ram_we=1, ram_addr=latched addr, ram_din=latched data, ram_match_en=0.
  - Then RESP with hit=0, rsp_addr=addr.
  - Write latency: accept at cycle T, ram_we high at T+1, rsp_valid at T+2.
- SCAN:
  - ram_match_en=1, ram_we=0; ram_addr starts at 0 and increments by 1 each cycle.
  - A one-deep pipeline register holds the address issued in the previous cycle plus a valid bit.
  - Each cycle with pipeline valid: compare ram_dout against the key.
  - First equality: stop issuing and go to RESP with hit=1, rsp_addr=pipelined address. Addresses already issued beyond the hit are discarded.
  - When ram_addr == limit is issued, go to DRAIN.
- DRAIN (1 cycle):
  - ram_match_en=0; compare the last word.
  - Go to RESP with hit=1/addr on match, else hit=0, rsp_addr=limit.
- RESP (1 cycle): rsp_valid=1, rsp_hit/rsp_addr driven, then IDLE. rsp_hit/rsp_addr hold their values until the next response.
- Search latency:
  - Hit at address k: rsp_valid at T+k+3.
  - Miss: rsp_valid at T+limit+3.
- Boundaries:
  - limit=0 scans exactly address 0.
  - limit=2**ADDR_W-1 scans the full RAM; the address counter must not wrap before termination.
  - Duplicate keys report the lowest address.
- Commands arriving while busy are ignored; cmd_ready=0 there, so the host must hold.
- rst asserted mid-WRITE or mid-SCAN aborts the operation: no response, all outputs take reset values the next cycle. The RAM contents are not affected except by a write already clocked.
- No backpressure on rsp.

Optional Feature:
CAM_VALID_BITS_EN
- With the macro: a 2**ADDR_W-bit valid register, cleared by rst.
  - A WRITE sets the bit for its address.
  - In SCAN/DRAIN an entry compares as a match only if key equality holds AND its valid bit is set.
  - The valid bit is pipelined alongside the address.
- Without the macro: every scanned address is compared. Uninitialised RAM contents may match.

Decomposition:
- Shared package/include cam_pkg:
  - DATA_W and ADDR_W defaults.
  - Opcode constants OP_WRITE=0, OP_SEARCH=1.
  - State encoding constants for IDLE..RESP.
- One natural sub-module: cam_scan_cmp.
  - Contains the pipeline register (address, valid, optional entry-valid) and the equality compare.
  - Produces hit and hit_addr.
- FSM and RAM port drivers stay in cam_search_ctrl.

Test Plan:
- Reset check: rst high 2 cycles -> cmd_ready=1, busy=0, rsp_valid=0, all ram_* = 0.
- Write then hit:
  - Write addr 0x005 data 0x0001 -> ram_we=1, ram_addr=0x005, ram_din=0x0001 at T+1; rsp_valid at T+2, rsp_hit=0, rsp_addr=0x005.
  - Then search key 0x0001, limit 0x00F -> rsp_hit=1, rsp_addr=0x005 at T+8.
- Duplicates: write 0x0002 to 0x003 and 0x009, search key 0x0002 limit 0x00F -> rsp_addr=0x003, and ram_addr never exceeds 0x004.
- Miss and limit:
  - Search key 0x3FFF limit 0x007 -> rsp_hit=0, rsp_addr=0x007 at T+10.
  - Search with limit 0x000 -> exactly one RAM read.
- Reset mid-search: assert rst during SCAN at ram_addr 0x004 -> no rsp_valid, outputs at reset values next cycle, the next command accepted normally.
- CAM_VALID_BITS_EN: after reset, search key 0x0000 over zero-filled RAM, limit 0x00F -> miss with the macro, hit at 0x000 without it.
